// File: rtl/scoped_readback.sv
// Tap readback: on request, waits HOLD_CYCLES settle cycles, captures one flattened tap
// and returns it over valid/ready with an error flag and a per-tap change flag.

module scoped_readback_tap #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] tap_i,
  input  logic                  upd_i,
  output logic                  chg_o
);
  logic                  seen_q, seen_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;

  always_comb begin
    seen_d = seen_q;
    last_d = last_q;
    if (upd_i) begin
      seen_d = 1'b1;
      last_d = tap_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_q <= 1'b0;
      last_q <= '0;
    end else begin
      seen_q <= seen_d;
      last_q <= last_d;
    end
  end

  // A never-read tap always reports a change.
  assign chg_o = ~seen_q | (tap_i != last_q);
endmodule

module scoped_readback #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_TAPS    = 3,
  parameter int ADDR_WIDTH  = 2,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_TAPS*DATA_WIDTH-1:0] taps_i,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic                           rsp_err,
  output logic                           rsp_chg
);
  localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]      HOLD_C = HOLD_CYCLES[CNT_W-1:0];
  localparam logic [ADDR_WIDTH:0]   NT_C   = NUM_TAPS[ADDR_WIDTH:0];

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic                  chg_q, chg_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;

  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] tap_arr;
  logic [NUM_TAPS-1:0]                 hit_vec, chg_vec, upd_vec;
  logic [DATA_WIDTH-1:0]               sel_tap;
  logic                                sel_chg, in_range, capture;

  assign tap_arr  = taps_i;
  assign in_range = {1'b0, addr_q} < NT_C;

  always_comb begin
    hit_vec = '0;
    sel_tap = '0;
    sel_chg = 1'b0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (addr_q == ADDR_WIDTH'(k)) begin
        hit_vec[k] = 1'b1;
        sel_tap    = tap_arr[k];
        sel_chg    = chg_vec[k];
      end
    end
  end

  assign upd_vec = hit_vec & {NUM_TAPS{capture}};

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    scoped_readback_tap #(.DATA_WIDTH(DATA_WIDTH)) u_tap (
      .clk   (clk),
      .rst_n (rst_n),
      .tap_i (tap_arr[k]),
      .upd_i (upd_vec[k]),
      .chg_o (chg_vec[k])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    chg_d   = chg_q;
    capture = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d  = req_addr;
        cnt_d   = HOLD_C;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = RESP;
          if (in_range) begin
            capture = 1'b1;
            data_d  = sel_tap;
            err_d   = 1'b0;
            chg_d   = sel_chg;
          end else begin
            data_d  = '0;
            err_d   = 1'b1;
            chg_d   = 1'b0;
          end
        end
      end
      RESP: if (rsp_ready) begin
        // Data is left in place after the handshake; only the flags drop.
        state_d = IDLE;
        err_d   = 1'b0;
        chg_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      chg_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      err_q       <= err_d;
      chg_q       <= chg_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign rsp_chg   = chg_q;
endmodule

// File: tb/tb_scoped_readback.sv
// Randomized bench for scoped_readback against a per-tap history model.

module tb_scoped_readback;
  localparam int DW = 8, NT = 3, AW = 2, HOLD = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] tap_v [NT];
  logic [NT*DW-1:0] taps_i;
  logic          req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, rsp_chg;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] rsp_data;

  bit            seen [NT];
  logic [DW-1:0] last [NT];
  int            n_cmp = 0, n_bad = 0;

  assign taps_i = {tap_v[2], tap_v[1], tap_v[0]};

  always #5 clk = ~clk;

  scoped_readback #(.DATA_WIDTH(DW), .NUM_TAPS(NT), .ADDR_WIDTH(AW), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .taps_i(taps_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_chg(rsp_chg)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NT; k++) begin
      seen[k] = 1'b0;
      last[k] = '0;
    end
  endtask

  // One full read: accept, latency, capture, optional backpressure with a tap poke, handshake.
  task automatic do_read(input int a, input int dly, input int tgi, input logic [DW-1:0] tgv);
    logic [DW-1:0] ed;
    bit ee, ec;
    int n;
    if (a < NT) begin
      ed = tap_v[a];
      ec = !seen[a] || (last[a] != ed);
      ee = 1'b0;
      seen[a] = 1'b1;
      last[a] = ed;
    end else begin
      ed = '0; ee = 1'b1; ec = 1'b0;
    end
    chk("req_ready_idle", req_ready, 1);
    req_addr  = AW'(a);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, HOLD + 1);
    chk("rsp_data", rsp_data, ed);
    chk("rsp_err", rsp_err, ee);
    chk("rsp_chg", rsp_chg, ec);
    chk("req_ready_busy", req_ready, 0);
    if (tgi >= 0) tap_v[tgi] = tgv;
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, ed);
      chk("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("hs_valid", rsp_valid, 0);
    chk("hs_err", rsp_err, 0);
    chk("hs_chg", rsp_chg, 0);
    chk("hs_data_kept", rsp_data, ed);
    chk("hs_req_ready", req_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_addr = '0;
    tap_v[0] = 8'h42; tap_v[1] = 8'h43; tap_v[2] = 8'h44;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_chg", rsp_chg, 0);

    do_read(1, 0, -1, 8'h00);          // first read -> 43, chg
    do_read(1, 0, -1, 8'h00);          // same value -> no chg
    tap_v[1] = 8'h55;
    do_read(1, 0, -1, 8'h00);          // 55, chg
    do_read(2, 0, -1, 8'h00);          // first read of tap 2
    do_read(0, 5, 0, 8'h99);           // backpressure while x moves 42->99
    do_read(3, 1, -1, 8'h00);          // out-of-range address
    do_read(0, 0, -1, 8'h00);          // normal after error (99 vs 42 -> chg)

    // Reset one cycle into WAIT: transaction dropped, history wiped.
    tap_v[0] = 8'h42;
    req_addr = '0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < HOLD + 3; i++) begin
      chk("midrst_no_valid", rsp_valid, 0);
      chk("midrst_req_ready", req_ready, 1);
      @(posedge clk); #1;
    end
    do_read(0, 0, -1, 8'h00);

    for (int t = 0; t < 40; t++) begin
      int a, dly, tgi;
      if ($urandom % 2 == 0) tap_v[$urandom % NT] = 8'($urandom);
      a   = int'($urandom % 4);
      dly = int'($urandom % 4);
      tgi = ($urandom % 3 == 0) ? int'($urandom % NT) : -1;
      do_read(a, dly, tgi, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
